// File: rtl/alu_seq_if.sv
// Request/result handshake bundle for alu_seq.
// The producer/consumer side takes the master modport, the ALU takes slave.
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_z;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_z, out_err
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_z, out_err
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked execute-stage ALU: 16 single-cycle ops plus iterative
// multiply/divide sharing one 2*WIDTH accumulator, one bit per cycle.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_XOR  = 5'd2;
  localparam logic [4:0] OP_ANDN = 5'd3;
  localparam logic [4:0] OP_ROL  = 5'd4;
  localparam logic [4:0] OP_SLL  = 5'd5;
  localparam logic [4:0] OP_ROR  = 5'd6;
  localparam logic [4:0] OP_SRL  = 5'd7;
  localparam logic [4:0] OP_BTR  = 5'd8;
  localparam logic [4:0] OP_EQZ  = 5'd9;
  localparam logic [4:0] OP_SCO  = 5'd10;
  localparam logic [4:0] OP_LBI  = 5'd11;
  localparam logic [4:0] OP_SEQ  = 5'd12;
  localparam logic [4:0] OP_SLBI = 5'd13;
  localparam logic [4:0] OP_SLT  = 5'd14;
  localparam logic [4:0] OP_SLE  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_MULH = 5'd17;
  localparam logic [4:0] OP_DIVU = 5'd18;
  localparam logic [4:0] OP_REMU = 5'd19;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] f_bitrev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  state_t             r_state;
  logic [SHW-1:0]     r_cnt;
  logic [4:0]         r_op;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_data;
  logic               r_z;
  logic               r_err;

  logic               w_accept;
  logic               w_is_multi;
  logic               w_illegal;
  logic [WIDTH:0]     w_sum;
  logic [SHW-1:0]     w_sh;
  logic [2*WIDTH-1:0] w_rol;
  logic [2*WIDTH-1:0] w_ror;
  logic [WIDTH-1:0]   w_alu;
  logic               w_is_div;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_rem;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_multi_res;
  logic               w_multi_err;

  // in_ready depends only on state and out_ready, never on in_valid
  assign bus.in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && bus.out_ready);
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.out_z     = r_z;
  assign bus.out_err   = r_err;

  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_is_multi = (bus.in_op >= OP_MUL) && (bus.in_op <= OP_REMU);
  assign w_illegal  = (bus.in_op > OP_REMU);
  assign w_is_div   = (r_op == OP_DIVU) || (r_op == OP_REMU);

  // Single-cycle result from the operands presented at acceptance
  always_comb begin
    w_sum = {1'b0, bus.in_a} + {1'b0, bus.in_b};
    w_sh  = bus.in_b[SHW-1:0];
    w_rol = {bus.in_a, bus.in_a} << w_sh;
    w_ror = {bus.in_a, bus.in_a} >> w_sh;
    w_alu = {WIDTH{1'b0}};
    case (bus.in_op)
      OP_ADD:  w_alu = w_sum[WIDTH-1:0];
      OP_SUB:  w_alu = bus.in_b - bus.in_a;
      OP_XOR:  w_alu = bus.in_a ^ bus.in_b;
      OP_ANDN: w_alu = bus.in_a & ~bus.in_b;
      OP_ROL:  w_alu = w_rol[2*WIDTH-1:WIDTH];
      OP_SLL:  w_alu = bus.in_a << w_sh;
      OP_ROR:  w_alu = w_ror[WIDTH-1:0];
      OP_SRL:  w_alu = bus.in_a >> w_sh;
      OP_BTR:  w_alu = f_bitrev(bus.in_a);
      OP_EQZ:  w_alu = bus.in_a;
      OP_SCO:  w_alu = {{(WIDTH-1){1'b0}}, w_sum[WIDTH]};
      OP_LBI:  w_alu = bus.in_b;
      OP_SEQ:  w_alu = {{(WIDTH-1){1'b0}}, (bus.in_a == bus.in_b)};
      OP_SLBI: w_alu = (bus.in_a << (WIDTH / 2)) | bus.in_b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) < $signed(bus.in_b))};
      OP_SLE:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(bus.in_a) <= $signed(bus.in_b))};
      default: w_alu = {WIDTH{1'b0}};
    endcase
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  // With a zero divisor every subtract succeeds, so the quotient saturates
  // to all-ones and the remainder half ends up holding A unmodified.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    w_div_rem  = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_div_rem - {1'b0, r_b};
    if (w_is_div) begin
      if (!w_div_diff[WIDTH]) begin
        w_acc_nxt = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      end else begin
        w_acc_nxt = {w_div_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_acc_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    end
    case (r_op)
      OP_MULH, OP_REMU: w_multi_res = w_acc_nxt[2*WIDTH-1:WIDTH];
      OP_MUL,  OP_DIVU: w_multi_res = w_acc_nxt[WIDTH-1:0];
      default:          w_multi_res = {WIDTH{1'b0}};
    endcase
    w_multi_err = w_is_div && (r_b == {WIDTH{1'b0}});
  end

  // Control FSM with registered result, flags and out_valid
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= {SHW{1'b0}};
      r_op        <= 5'd0;
      r_acc       <= {(2*WIDTH){1'b0}};
      r_b         <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_data      <= {WIDTH{1'b0}};
      r_z         <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_op <= bus.in_op;
            if (w_is_multi) begin
              r_state     <= ST_BUSY;
              r_cnt       <= {SHW{1'b0}};
              r_acc       <= {{WIDTH{1'b0}}, bus.in_a};
              r_b         <= bus.in_b;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b1;
              r_data      <= w_alu;
              r_z         <= (w_alu == {WIDTH{1'b0}});
              r_err       <= w_illegal;
            end
          end else if ((r_state == ST_DONE) && bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end else begin
            r_state <= r_state;
          end
        end
        ST_BUSY: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt + {{(SHW-1){1'b0}}, 1'b1};
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_data      <= w_multi_res;
            r_z         <= (w_multi_res == {WIDTH{1'b0}});
            r_err       <= w_multi_err;
          end else begin
            r_state <= ST_BUSY;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at WIDTH=16: expected results are queued when
// a request is driven and popped when the DUT presents out_valid.
module tb_alu_seq;

  typedef struct packed {
    logic [15:0] data;
    logic        z;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  exp_t sb_q[$];

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t ref_model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    logic [31:0] p;
    logic [16:0] s;
    int          sh;
    sh    = int'(b[3:0]);
    p     = {16'd0, a} * {16'd0, b};
    s     = {1'b0, a} + {1'b0, b};
    e.err = 1'b0;
    case (op)
      5'd0:  e.data = a + b;
      5'd1:  e.data = b - a;
      5'd2:  e.data = a ^ b;
      5'd3:  e.data = a & ~b;
      5'd4:  e.data = (a << sh) | (a >> (16 - sh));
      5'd5:  e.data = a << sh;
      5'd6:  e.data = (a >> sh) | (a << (16 - sh));
      5'd7:  e.data = a >> sh;
      5'd8:  for (int i = 0; i < 16; i++) e.data[15-i] = a[i];
      5'd9:  e.data = a;
      5'd10: e.data = {15'd0, s[16]};
      5'd11: e.data = b;
      5'd12: e.data = (a == b) ? 16'd1 : 16'd0;
      5'd13: e.data = {a[7:0], 8'd0} | b;
      5'd14: e.data = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      5'd15: e.data = ($signed(a) <= $signed(b)) ? 16'd1 : 16'd0;
      5'd16: e.data = p[15:0];
      5'd17: e.data = p[31:16];
      5'd18: begin e.data = (b == 16'd0) ? 16'hFFFF : a / b; e.err = (b == 16'd0); end
      5'd19: begin e.data = (b == 16'd0) ? a : a % b;        e.err = (b == 16'd0); end
      default: begin e.data = 16'd0; e.err = 1'b1; end
    endcase
    e.z = (e.data == 16'd0);
    return e;
  endfunction

  // Drives one request with out_ready=1 and collects the result; no checking.
  task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       output exp_t got, output int lat, output logic tmo, output logic rdy_busy);
    int w;
    got = '0; lat = 0; tmo = 1'b0; rdy_busy = 1'b0; w = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.out_ready = 1'b1;
    while (!bus.in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      tmo = 1'b1;
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_op    = 5'($urandom);
    bus.in_a     = 16'($urandom);
    bus.in_b     = 16'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_busy = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      tmo = 1'b1;
    end else begin
      got = '{data: bus.out_data, z: bus.out_z, err: bus.out_err};
    end
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 5'd0; bus.in_a = 16'd0; bus.in_b = 16'd0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if (bus.out_data !== 16'd0)  begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data); end
    n_cmp++; if (bus.out_z !== 1'b1)      begin n_fail++; $display("FAIL reset_out_z: got %b expected 1", bus.out_z); end
    n_cmp++; if (bus.out_err !== 1'b0)    begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err); end
  endtask

  // Directed single-cycle and shift cases with fixed expected values
  task automatic test_alu();
    logic [4:0] op; logic [15:0] a, b; exp_t ex, got; int lat; logic tmo, rb;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0: begin op = 5'd0;  a = 16'h7FFF; b = 16'h0001; ex = '{16'h8000, 1'b0, 1'b0}; end
        1: begin op = 5'd1;  a = 16'd3;    b = 16'd10;   ex = '{16'h0007, 1'b0, 1'b0}; end
        2: begin op = 5'd13; a = 16'h00AB; b = 16'h0012; ex = '{16'hAB12, 1'b0, 1'b0}; end
        3: begin op = 5'd8;  a = 16'h0001; b = 16'h0000; ex = '{16'h8000, 1'b0, 1'b0}; end
        4: begin op = 5'd10; a = 16'hFFFF; b = 16'h0001; ex = '{16'h0001, 1'b0, 1'b0}; end
        5: begin op = 5'd14; a = 16'h8000; b = 16'h7FFF; ex = '{16'h0001, 1'b0, 1'b0}; end
        6: begin op = 5'd15; a = 16'd5;    b = 16'd5;    ex = '{16'h0001, 1'b0, 1'b0}; end
        7: begin op = 5'd4;  a = 16'h8001; b = 16'h0013; ex = '{16'h000C, 1'b0, 1'b0}; end
        default: begin op = 5'd7; a = 16'h8000; b = 16'h0013; ex = '{16'h1000, 1'b0, 1'b0}; end
      endcase
      sb_q.push_back(ex);
      do_op(op, a, b, got, lat, tmo, rb);
      ex = sb_q.pop_front();
      n_cmp++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL alu_timeout[%0d]: got timeout expected result", i); end
      n_cmp++; if (got !== ex)   begin n_fail++; $display("FAIL alu_result[%0d]: got %h/z%b/e%b expected %h/z%b/e%b", i, got.data, got.z, got.err, ex.data, ex.z, ex.err); end
      n_cmp++; if (lat !== 1)    begin n_fail++; $display("FAIL alu_latency[%0d]: got %0d expected 1", i, lat); end
    end
  endtask

  task automatic test_muldiv();
    logic [4:0] op; logic [15:0] a, b; exp_t ex, got; int lat, exp_lat; logic tmo, rb;
    for (int i = 0; i < 8; i++) begin
      exp_lat = 17;
      case (i)
        0: begin op = 5'd16; a = 16'd3;    b = 16'd5;    ex = '{16'h000F, 1'b0, 1'b0}; end
        1: begin op = 5'd17; a = 16'hFFFF; b = 16'hFFFF; ex = '{16'hFFFE, 1'b0, 1'b0}; end
        2: begin op = 5'd16; a = 16'hFFFF; b = 16'hFFFF; ex = '{16'h0001, 1'b0, 1'b0}; end
        3: begin op = 5'd18; a = 16'd100;  b = 16'd7;    ex = '{16'h000E, 1'b0, 1'b0}; end
        4: begin op = 5'd19; a = 16'd100;  b = 16'd7;    ex = '{16'h0002, 1'b0, 1'b0}; end
        5: begin op = 5'd18; a = 16'h1234; b = 16'h0000; ex = '{16'hFFFF, 1'b0, 1'b1}; end
        6: begin op = 5'd19; a = 16'h1234; b = 16'h0000; ex = '{16'h1234, 1'b0, 1'b1}; end
        default: begin op = 5'd25; a = 16'h5A5A; b = 16'h1111; ex = '{16'h0000, 1'b1, 1'b1}; exp_lat = 1; end
      endcase
      sb_q.push_back(ex);
      do_op(op, a, b, got, lat, tmo, rb);
      ex = sb_q.pop_front();
      n_cmp++; if (tmo !== 1'b0)     begin n_fail++; $display("FAIL md_timeout[%0d]: got timeout expected result", i); end
      n_cmp++; if (got !== ex)       begin n_fail++; $display("FAIL md_result[%0d]: got %h/z%b/e%b expected %h/z%b/e%b", i, got.data, got.z, got.err, ex.data, ex.z, ex.err); end
      n_cmp++; if (lat !== exp_lat)  begin n_fail++; $display("FAIL md_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      n_cmp++; if (rb !== 1'b0)      begin n_fail++; $display("FAIL md_busy_ready[%0d]: got in_ready=1 while busy expected 0", i); end
    end
  endtask

  task automatic test_random();
    logic [4:0] op; logic [15:0] a, b; exp_t ex, got; int lat, exp_lat; logic tmo, rb;
    for (int i = 0; i < 24; i++) begin
      op = 5'($urandom_range(0, 31));
      a  = 16'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      exp_lat = (op >= 5'd16 && op <= 5'd19) ? 17 : 1;
      sb_q.push_back(ref_model(op, a, b));
      do_op(op, a, b, got, lat, tmo, rb);
      ex = sb_q.pop_front();
      n_cmp++; if (tmo !== 1'b0 || got !== ex) begin n_fail++; $display("FAIL rnd_result[%0d] op=%0d a=%h b=%h: got %h/z%b/e%b expected %h/z%b/e%b", i, op, a, b, got.data, got.z, got.err, ex.data, ex.z, ex.err); end
      n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t ex;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 5'd0; bus.in_a = 16'd2; bus.in_b = 16'd3; bus.out_ready = 1'b0;
    sb_q.push_back('{16'h0005, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    bus.in_op = 5'd2; bus.in_a = 16'hF0F0; bus.in_b = 16'h0FF0;
    sb_q.push_back('{16'hFF00, 1'b0, 1'b0});
    ex = sb_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({bus.out_valid, bus.out_data, bus.out_z, bus.out_err, bus.in_ready} !== {1'b1, ex.data, ex.z, ex.err, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got v%b %h z%b e%b rdy%b expected v1 %h z%b e%b rdy0", c, bus.out_valid, bus.out_data, bus.out_z, bus.out_err, bus.in_ready, ex.data, ex.z, ex.err);
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    ex = sb_q.pop_front();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== ex.data) begin n_fail++; $display("FAIL bp_xor_next: got v%b %h expected v1 %h", bus.out_valid, bus.out_data, ex.data); end
    @(posedge clk);
  endtask

  task automatic test_reset_midop();
    exp_t ex, got; int lat; logic tmo, rb, stale;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_op = 5'd18; bus.in_a = 16'd100; bus.in_b = 16'd7; bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_op = 5'd0; bus.in_a = 16'd5; bus.in_b = 16'd5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", bus.out_valid); end
    n_cmp++; if ({bus.out_data, bus.out_z, bus.out_err} !== {16'd0, 1'b1, 1'b0}) begin n_fail++; $display("FAIL rmid_outputs: got %h z%b e%b expected 0000 z1 e0", bus.out_data, bus.out_z, bus.out_err); end
    stale = 1'b0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.out_valid) stale = 1'b1;
    end
    n_cmp++; if (stale !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got out_valid=1 expected no result"); end
    sb_q.push_back('{16'h0002, 1'b0, 1'b0});
    do_op(5'd0, 16'd1, 16'd1, got, lat, tmo, rb);
    ex = sb_q.pop_front();
    n_cmp++; if (tmo !== 1'b0 || got !== ex) begin n_fail++; $display("FAIL rmid_add: got %h/z%b/e%b expected %h", got.data, got.z, got.err, ex.data); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_alu();
    test_muldiv();
    test_back_to_back();
    test_reset_midop();
    test_random();
    if (sb_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 16-bit combinational datapath ALU. It keeps the full 16-operation set, generalised to any `WIDTH`, and adds iterative multiply/divide ops that take `WIDTH` cycles. Sits in the execute stage between operand latch and writeback. Single-cycle ops still answer in one cycle; multi-cycle ops stall the producer through `in_ready`.

## Interface
- `WIDTH`, 16: datapath width. Must be a power of two, ≥ 8.
- `SHW`, $clog2(WIDTH): shift-amount width. Derived; do not override.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block can accept a request this cycle.
- `in_op`  in  5  opcode.
- `in_a`  in  WIDTH  operand A.
- `in_b`  in  WIDTH  operand B.
- `out_valid`  out  1  result held on `out_*`.
- `out_ready`  in  1  consumer takes the result.
- `out_data`  out  WIDTH  result.
- `out_z`  out  1  `out_data == 0`.
- `out_err`  out  1  illegal opcode or divide by zero.

## Operation
- Clocking: one clock; reset is synchronous and active-high.
- Handshake:
  - Request accepted when `in_valid & in_ready`.
  - Result consumed when `out_valid & out_ready`.
  - `in_a`, `in_b`, `in_op` are captured at acceptance; later changes are ignored.
- State machine: IDLE, BUSY, DONE.
  - IDLE: `in_ready=1`. A single-cycle op goes to DONE with its result registered. A multi-cycle op goes to BUSY with counter=0.
  - BUSY: `in_ready=0`. One iteration per cycle. When counter reaches WIDTH-1, go to DONE.
  - DONE: `out_valid=1`, outputs stable.
    - `in_ready = out_ready`.
    - On `out_ready` with a new accepted request, go directly to DONE or BUSY per the new op (back-to-back).
    - On `out_ready` without a request, go to IDLE.
- Single-cycle ops (A, B as captured; arithmetic mod 2^WIDTH):
  - 0 ADD: A+B.
  - 1 SUB: B−A.
  - 2 XOR: A^B.
  - 3 ANDN: A&~B.
  - 4 ROL: rotate A left by B[SHW-1:0].
  - 5 SLL: shift A left by B[SHW-1:0].
  - 6 ROR: rotate A right by B[SHW-1:0].
  - 7 SRL: logical shift A right by B[SHW-1:0].
  - 8 BTR: bit-reverse A.
  - 9 EQZ: result A; `out_z` is the flag of interest.
  - 10 SCO: carry-out of A+B, zero-extended.
  - 11 LBI: B.
  - 12 SEQ: A==B ? 1 : 0.
  - 13 SLBI: (A << WIDTH/2) | B.
  - 14 SLT: signed A<B ? 1 : 0.
  - 15 SLE: signed A≤B ? 1 : 0.
  - Signed compares must be correct when A and B have opposite signs (no overflow error).
- Multi-cycle ops (unsigned):
  - 16 MUL: low WIDTH bits of A·B.
  - 17 MULH: high WIDTH bits of A·B.
  - 18 DIVU: A/B.
  - 19 REMU: A%B.
  - Implementation: one shared 2·WIDTH accumulator. Shift-add for multiply, restoring shift-subtract for divide, one bit per cycle.
- Divide by zero (B==0): DIVU returns all-ones, REMU returns A, `out_err=1`. Still takes the full BUSY duration.
- Illegal op (20–31): single-cycle, `out_data=0`, `out_z=1`, `out_err=1`.
- `out_z` and `out_err` are registered together with `out_data`.

## Timing
- Reset values: state IDLE, `in_ready=1`, `out_valid=0`, `out_data=0`, `out_z=1`, `out_err=0`, counter=0.
- Reset mid-BUSY or mid-DONE:
  - The in-flight op is discarded; no `out_valid` is produced for it.
  - A request presented in the reset cycle is not accepted.
- Single-cycle latency: accept in cycle N, `out_valid=1` in cycle N+1.
- Multi-cycle latency: accept in cycle N, BUSY for cycles N+1..N+WIDTH, `out_valid=1` in cycle N+WIDTH+1.
- Throughput: one single-cycle op per clock while `out_ready=1`. One multi-cycle op per WIDTH+1 clocks.
- Backpressure: `out_valid` stays high and `out_*` hold until `out_ready`. No result is ever dropped or overwritten.
- `in_ready` is combinational from state and `out_ready` only, never from `in_valid`.

## Test plan
- Reset then ALU sweep, WIDTH=16, `out_ready=1`:
  - ADD 0x7FFF+0x0001 → 0x8000.
  - SUB A=3, B=10 → 0x0007.
  - SLBI A=0x00AB, B=0x0012 → 0xAB12.
  - BTR 0x0001 → 0x8000.
  - SCO 0xFFFF+0x0001 → 0x0001, `out_z=0`.
  - SLT A=0x8000, B=0x7FFF → 1.
  - SLE A=5, B=5 → 1.
  - Each result appears exactly 1 cycle after acceptance.
- Shifts with B=0x0013 (only low 4 bits used):
  - ROL 0x8001 by 3 → 0x000C.
  - SRL 0x8000 by 3 → 0x1000.
- Multiply:
  - MUL 3·5 → 0x000F at acceptance+17.
  - MULH 0xFFFF·0xFFFF → 0xFFFE; MUL of the same operands → 0x0001.
  - `in_ready=0` throughout BUSY.
- Divide:
  - DIVU 100/7 → 0x000E.
  - REMU 100%7 → 0x0002.
  - DIVU 0x1234/0 → 0xFFFF with `out_err=1`.
  - REMU 0x1234%0 → 0x1234 with `out_err=1`.
  - Illegal op 25 → 0, `out_z=1`, `out_err=1`.
- Backpressure:
  - Hold `out_ready=0` for 5 cycles after an ADD result: `out_*` stable, `in_ready=0`.
  - Raise `out_ready` with a queued XOR request: XOR result on the next cycle, no bubble.
- Reset mid-op:
  - Assert `rst` 6 cycles into a DIVU: next cycle is IDLE with all reset values.
  - No stale result ever appears.
  - A following ADD 1+1 → 0x0002.
